// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the block-scaled accumulator.
// Optional: DOT_ACC_STICKY_EN enables the o_inexact sticky output.
package dot_acc_pkg;

    localparam int SCALE_W = 8;
    localparam logic [SCALE_W-1:0] SCALE_MAX = 8'd255;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } dot_acc_state_t;

endpackage

// File: rtl/acc_align_shr.sv
// Arithmetic right shift with sign fill for shifts at or beyond width.
// o_sticky flags that a nonzero bit was shifted out.
module acc_align_shr
    import dot_acc_pkg::*;
#(
    parameter int width = 24
) (
    input  logic signed [width-1:0]   i_val,
    input  logic        [SCALE_W-1:0] i_sh,
    output logic signed [width-1:0]   o_val,
    output logic                      o_sticky
);

    logic [width-1:0] w_mask;

    assign w_mask = ~({width{1'b1}} << i_sh);

    always_comb begin
        o_val    = i_val;
        o_sticky = 1'b0;
        if (int'(i_sh) >= width) begin
            o_val    = {width{i_val[width-1]}};
            o_sticky = |i_val;
        end else begin
            o_val    = i_val >>> i_sh;
            o_sticky = |(i_val & w_mask);
        end
    end

endmodule

// File: rtl/dot_acc_int.sv
// Streaming block-scaled accumulator with align, add and renormalise.
// Optional: DOT_ACC_STICKY_EN adds the o_inexact sticky output.
module dot_acc_int
    import dot_acc_pkg::*;
#(
    parameter int in_width  = 18,
    parameter int acc_width = 24,
    parameter int beat_w    = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [in_width-1:0]  i_dp,
    input  logic        [SCALE_W-1:0]   i_scale,
    input  logic                        i_last,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [acc_width-1:0] o_dp,
    output logic        [SCALE_W-1:0]   o_scale,
    output logic        [beat_w-1:0]    o_beats,
    output logic                        o_overflow
`ifdef DOT_ACC_STICKY_EN
    ,
    output logic                        o_inexact
`endif
);

    localparam int AW = acc_width;

    dot_acc_state_t r_state;
    dot_acc_state_t w_next;

    logic signed [AW-1:0]      r_acc;
    logic        [SCALE_W-1:0] r_scale;
    logic        [beat_w-1:0]  r_beats;
    logic                      r_ovf;

    logic                      w_xfer;
    logic signed [AW-1:0]      w_in_ext;
    logic                      w_gt;
    logic        [SCALE_W-1:0] w_d;
    logic        [SCALE_W-1:0] w_acc_sh;
    logic        [SCALE_W-1:0] w_in_sh;
    logic signed [AW-1:0]      w_acc_al;
    logic signed [AW-1:0]      w_in_al;
    logic                      w_acc_st;
    logic                      w_in_st;
    logic        [AW:0]        w_sum;
    logic                      w_norm;
    logic        [SCALE_W-1:0] w_base_scale;
    logic                      w_sat;
    logic signed [AW-1:0]      w_acc_nx;
    logic        [SCALE_W-1:0] w_scale_nx;
    logic        [beat_w-1:0]  w_beats_inc;

    assign o_ready    = (r_state != S_OUT);
    assign o_valid    = (r_state == S_OUT);
    assign o_dp       = r_acc;
    assign o_scale    = r_scale;
    assign o_beats    = r_beats;
    assign o_overflow = r_ovf;

    assign w_xfer   = i_valid && o_ready;
    assign w_in_ext = AW'(i_dp);
    assign w_gt     = (i_scale > r_scale);
    assign w_d      = w_gt ? (i_scale - r_scale) : (r_scale - i_scale);
    assign w_acc_sh = w_gt ? w_d : '0;
    assign w_in_sh  = w_gt ? '0 : w_d;

    acc_align_shr #(.width(AW)) u_acc_shr (
        .i_val    (r_acc),
        .i_sh     (w_acc_sh),
        .o_val    (w_acc_al),
        .o_sticky (w_acc_st)
    );

    acc_align_shr #(.width(AW)) u_in_shr (
        .i_val    (w_in_ext),
        .i_sh     (w_in_sh),
        .o_val    (w_in_al),
        .o_sticky (w_in_st)
    );

    // One guard bit: top two bits differing means the sum left acc range
    assign w_sum        = {w_acc_al[AW-1], w_acc_al} + {w_in_al[AW-1], w_in_al};
    assign w_norm       = w_sum[AW] ^ w_sum[AW-1];
    assign w_base_scale = w_gt ? i_scale : r_scale;
    assign w_sat        = w_norm && (w_base_scale == SCALE_MAX);
    assign w_beats_inc  = (&r_beats) ? r_beats : r_beats + 1'b1;

    always_comb begin
        w_acc_nx   = w_sum[AW-1:0];
        w_scale_nx = w_base_scale;
        if (w_norm) begin
            if (w_sat) begin
                w_acc_nx = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                                     : {1'b0, {(AW-1){1'b1}}};
            end else begin
                w_acc_nx   = w_sum[AW:1];
                w_scale_nx = w_base_scale + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_xfer) w_next = i_last ? S_OUT : S_ACC;
            end
            S_OUT: begin
                if (i_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_scale <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_acc   <= w_in_ext;
                        r_scale <= i_scale;
                        r_beats <= beat_w'(1);
                        r_ovf   <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (w_xfer) begin
                        r_acc   <= w_acc_nx;
                        r_scale <= w_scale_nx;
                        r_beats <= w_beats_inc;
                        r_ovf   <= r_ovf | w_sat;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        r_beats <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DOT_ACC_STICKY_EN
    logic r_inexact;

    assign o_inexact = r_inexact;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_xfer) r_inexact <= 1'b0;
                S_ACC: begin
                    if (w_xfer) begin
                        r_inexact <= r_inexact | w_acc_st | w_in_st
                                   | (w_norm && !w_sat && w_sum[0]);
                    end
                end
                S_OUT: if (i_ready) r_inexact <= 1'b0;
                default: ;
            endcase
        end
    end
`else
    logic w_unused;

    assign w_unused = w_acc_st ^ w_in_st;
`endif

endmodule

// File: tb/tb_dot_acc_int.sv
// Self-checking bench for dot_acc_int: vector table, corner sequences,
// and randomized results checked against an arithmetic reference model.
module tb_dot_acc_int;

    localparam int IW = 18;
    localparam int AW = 18;
    localparam int BW = 8;
    localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW-1));

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 i_last = 1'b0;
    logic                 i_ready = 1'b0;
    logic signed [IW-1:0] i_dp = '0;
    logic        [7:0]    i_scale = '0;
    logic                 o_ready;
    logic                 o_valid;
    logic                 o_overflow;
    logic signed [AW-1:0] o_dp;
    logic        [7:0]    o_scale;
    logic        [BW-1:0] o_beats;
`ifdef DOT_ACC_STICKY_EN
    logic                 o_inexact;
`endif

    int checks = 0;
    int errors = 0;

    dot_acc_int #(.in_width(IW), .acc_width(AW), .beat_w(BW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_dp       (i_dp),
        .i_scale    (i_scale),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_dp       (o_dp),
        .o_scale    (o_scale),
        .o_beats    (o_beats),
        .o_overflow (o_overflow)
`ifdef DOT_ACC_STICKY_EN
        ,
        .o_inexact  (o_inexact)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0]           n;
        logic signed [IW-1:0] d0;
        logic signed [IW-1:0] d1;
        logic signed [IW-1:0] d2;
        logic [7:0]           s0;
        logic [7:0]           s1;
        logic [7:0]           s2;
        logic signed [AW-1:0] e_dp;
        logic [7:0]           e_sc;
        logic [7:0]           e_b;
        logic                 e_ovf;
        logic                 e_inx;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint dp, input int sc, input bit last);
        int t;
        t = 0;
        while (!o_ready && t < 50) begin
            tick();
            t++;
        end
        if (!o_ready) chk("send_timeout", 0, 1);
        i_valid = 1'b1;
        i_dp    = IW'(dp);
        i_scale = 8'(sc);
        i_last  = last;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic take(input string nm, input longint edp, input int esc,
                        input int eb, input bit eovf, input bit einx);
        int t;
        t = 0;
        while (!o_valid && t < 50) begin
            tick();
            t++;
        end
        chk({nm, "_valid"}, longint'(o_valid), 1);
        chk({nm, "_dp"}, longint'(o_dp), edp);
        chk({nm, "_scale"}, longint'(o_scale), longint'(esc));
        chk({nm, "_beats"}, longint'(o_beats), longint'(eb));
        chk({nm, "_ovf"}, longint'(o_overflow), longint'(eovf));
`ifdef DOT_ACC_STICKY_EN
        chk({nm, "_inexact"}, longint'(o_inexact), longint'(einx));
`else
        if (einx === 1'bx) chk({nm, "_inexact_x"}, 0, 1);
`endif
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    // Reference: exact arithmetic on the value/scale pair
    task automatic model_beat(input bit first, input longint dp, input int sc,
                              inout longint v, inout int s, inout int b,
                              inout bit ovf, inout bit inx);
        longint x;
        longint sum;
        int d;
        if (first) begin
            v = dp; s = sc; b = 1; ovf = 0; inx = 0;
            return;
        end
        if (sc > s) begin
            d = sc - s;
            if (d > 63) d = 63;
            if (((v >>> d) <<< d) != v) inx = 1;
            v = v >>> d;
            s = sc;
            x = dp;
        end else begin
            d = s - sc;
            if (d > 63) d = 63;
            if (((dp >>> d) <<< d) != dp) inx = 1;
            x = dp >>> d;
        end
        sum = v + x;
        if (sum > AMAX || sum < AMIN) begin
            if (s == 255) begin
                ovf = 1;
                sum = (sum > 0) ? AMAX : AMIN;
            end else begin
                if ((sum & 1) != 0) inx = 1;
                sum = sum >>> 1;
                s++;
            end
        end
        v = sum;
        b = (b < 255) ? b + 1 : 255;
    endtask

    initial begin
        tbl[0] = '{2'd1, 18'sd100, 18'sd0, 18'sd0, 8'd10, 8'd0, 8'd0,
                   18'sd100, 8'd10, 8'd1, 1'b0, 1'b0};
        tbl[1] = '{2'd3, 18'sd5, -18'sd3, 18'sd7, 8'd4, 8'd4, 8'd4,
                   18'sd9, 8'd4, 8'd3, 1'b0, 1'b0};
        tbl[2] = '{2'd2, 18'sd65, 18'sd8, 18'sd0, 8'd2, 8'd5, 8'd0,
                   18'sd16, 8'd5, 8'd2, 1'b0, 1'b1};
        tbl[3] = '{2'd2, 18'sd131071, 18'sd131071, 18'sd0, 8'd0, 8'd0, 8'd0,
                   18'sd131071, 8'd1, 8'd2, 1'b0, 1'b0};
        tbl[4] = '{2'd2, 18'sd131071, 18'sd131071, 18'sd0, 8'd255, 8'd255, 8'd0,
                   18'sd131071, 8'd255, 8'd2, 1'b1, 1'b0};
        tbl[5] = '{2'd2, -18'sd131072, -18'sd131072, 18'sd0, 8'd7, 8'd7, 8'd0,
                   -18'sd131072, 8'd8, 8'd2, 1'b0, 1'b0};
        tbl[6] = '{2'd2, 18'sd40, 18'sd7, 18'sd0, 8'd6, 8'd4, 8'd0,
                   18'sd41, 8'd6, 8'd2, 1'b0, 1'b1};
        tbl[7] = '{2'd2, -18'sd1, 18'sd5, 18'sd0, 8'd0, 8'd20, 8'd0,
                   18'sd4, 8'd20, 8'd2, 1'b0, 1'b1};
        tbl[8] = '{2'd2, -18'sd131072, -18'sd5, 18'sd0, 8'd255, 8'd255, 8'd0,
                   -18'sd131072, 8'd255, 8'd2, 1'b1, 1'b0};

        #12;
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_ready", longint'(o_ready), 1);
        chk("rst_dp", longint'(o_dp), 0);
        chk("rst_scale", longint'(o_scale), 0);
        chk("rst_beats", longint'(o_beats), 0);
        chk("rst_ovf", longint'(o_overflow), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            vec_t tv;
            longint d;
            int s;
            tv = tbl[i];
            for (int j = 0; j < int'(tv.n); j++) begin
                case (j)
                    0: begin d = longint'($signed(tv.d0)); s = int'(tv.s0); end
                    1: begin d = longint'($signed(tv.d1)); s = int'(tv.s1); end
                    default: begin d = longint'($signed(tv.d2)); s = int'(tv.s2); end
                endcase
                send(d, s, j == int'(tv.n) - 1);
            end
            chk($sformatf("vec%0d_valid_next", i), longint'(o_valid), 1);
            take($sformatf("vec%0d", i), longint'($signed(tv.e_dp)), int'(tv.e_sc),
                 int'(tv.e_b), tv.e_ovf, tv.e_inx);
        end

        // Backpressure: result held, upstream keeps offering a beat
        send(77, 3, 1);
        i_valid = 1'b1; i_dp = 18'sd11; i_scale = 8'd3; i_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", longint'(o_ready), 0);
            chk("bp_valid", longint'(o_valid), 1);
            chk("bp_dp", longint'(o_dp), 77);
            chk("bp_beats", longint'(o_beats), 1);
            tick();
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        i_valid = 1'b0;
        i_last = 1'b0;
        chk("bp_rel_valid", longint'(o_valid), 0);
        chk("bp_rel_ready", longint'(o_ready), 1);
        chk("bp_rel_beats", longint'(o_beats), 0);

        // i_ready while idle is ignored
        i_ready = 1'b1;
        tick();
        tick();
        chk("idle_rdy_valid", longint'(o_valid), 0);
        chk("idle_rdy_ready", longint'(o_ready), 1);
        i_ready = 1'b0;

        // Async reset mid-accumulation
        send(5, 0, 0);
        send(6, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(o_valid), 0);
        chk("mid_rst_ready", longint'(o_ready), 1);
        chk("mid_rst_dp", longint'(o_dp), 0);
        chk("mid_rst_scale", longint'(o_scale), 0);
        chk("mid_rst_beats", longint'(o_beats), 0);
        #3 rst_n = 1'b1;
        tick();
        send(3, 0, 1);
        take("post_rst", 3, 0, 1, 0, 0);

        // Beat counter saturation
        for (int k = 0; k < 260; k++) send(0, 0, k == 259);
        take("beat_sat", 0, 0, 255, 0, 0);

        // Randomized results against the reference model
        for (int r = 0; r < 40; r++) begin
            longint mv;
            int ms;
            int mb;
            bit movf;
            bit minx;
            int n;
            int base;
            n = int'($urandom_range(1, 6));
            base = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12))
                                               : int'($urandom_range(245, 255));
            mv = 0; ms = 0; mb = 0; movf = 0; minx = 0;
            for (int j = 0; j < n; j++) begin
                logic signed [IW-1:0] rd;
                longint dp;
                int sc;
                rd = IW'($urandom);
                dp = longint'(rd);
                if ($urandom_range(0, 3) == 0) dp = dp >>> 10;
                sc = base + int'($urandom_range(0, 6)) - 3;
                if (sc < 0) sc = 0;
                if (sc > 255) sc = 255;
                model_beat(j == 0, dp, sc, mv, ms, mb, movf, minx);
                if ($urandom_range(0, 3) == 0) tick();
                send(dp, sc, j == n - 1);
            end
            repeat ($urandom_range(0, 3)) tick();
            take($sformatf("rnd%0d", r), mv, ms, mb, movf, minx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_acc_int.md
# dot_acc_int

Streaming block-scaled accumulator placed directly downstream of the integer block dot-product stage. It consumes a sequence of (partial dot product, shared scale) beats over a valid/ready handshake. Each beat is aligned to the running scale and summed into one wide accumulator, with renormalisation on overflow. On the beat flagged last, it presents one (value, scale) result for the output stage.

## Interface
- `in_width`, default 18: signed width of incoming partial dot product (matches dot-stage `dp_width` for bit_width=8, k=4).
- `acc_width`, default 24: signed accumulator width; must be ≥ `in_width`.
- `beat_w`, default 8: width of beat counter.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  block can accept a beat.
- `i_dp`  in  `in_width`  signed partial dot product.
- `i_scale`  in  8  unsigned shared scale of `i_dp`.
- `i_last`  in  1  final beat of current accumulation.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_dp`  out  `acc_width`  signed accumulated value.
- `o_scale`  out  8  scale of `o_dp`.
- `o_beats`  out  `beat_w`  beats accumulated into result; saturates at all-ones.
- `o_overflow`  out  1  sticky per result: scale saturated at 255 and value clamped.

## Operation
- FSM states: S_IDLE (accumulator empty), S_ACC (accumulating), S_OUT (holding result).
- Input transfer = `i_valid && o_ready`. `o_ready` = 1 in S_IDLE and S_ACC, 0 in S_OUT.
- S_IDLE + transfer: acc ← sign-extend(`i_dp`), acc_scale ← `i_scale`, beats ← 1. Next state is S_OUT if `i_last`, else S_ACC.
- S_ACC + transfer: align, add, normalise. beats increments (saturating). Next state is S_OUT if `i_last`, else S_ACC.
- Alignment, d = |`i_scale` − acc_scale|:
  - If `i_scale` > acc_scale: acc shifts arithmetically right by d, and acc_scale ← `i_scale`.
  - Otherwise the sign-extended input shifts right by d.
  - d ≥ `acc_width` yields the operand's sign fill (0 or −1).
- Add at `acc_width`+1 bits. If the top two bits differ: arithmetic shift right by 1, scale+1.
- If normalisation is required with scale = 255: clamp to max/min signed `acc_width`, keep scale 255, set `o_overflow`.
- S_OUT: `o_valid`=1. Outputs stay stable until `i_ready`. On `i_ready`, go to S_IDLE and clear `o_overflow`/beats for the next result.
- Transfers during S_OUT are not accepted; upstream must hold.

## Timing
- Reset values: `o_valid`=0, `o_ready`=1, `o_dp`=0, `o_scale`=0, `o_beats`=0, `o_overflow`=0, state S_IDLE.
- One beat accepted per cycle.
- `o_valid` rises the cycle after the `i_last` transfer.
- Result handshake: `o_valid && i_ready` completes in one cycle. `o_ready` returns to 1 the cycle after, giving one bubble per result. Throughput is N beats + 1 cycle.
- `i_last` on the first beat produces a single-beat result.
- Reset asserted mid-accumulation or mid-hold discards all state immediately (async); no partial result is emitted.
- `i_ready` asserted while `o_valid`=0 has no effect.

## Configuration
- `DOT_ACC_STICKY_EN` defined: adds output `o_inexact` (1 bit, reset 0). It is sticky per result and set when any nonzero bit is discarded by alignment or normalisation. It clears with the result handshake.
- Undefined: port and logic are absent; discarded bits are silently truncated.

## Structure
- Package `dot_acc_pkg` holds:
  - state enum typedef `dot_acc_state_t`;
  - `SCALE_W` = 8;
  - `SCALE_MAX` = 8'd255.
- One sub-module, `acc_align_shr`: parameterised arithmetic right shift with sign fill at d ≥ width. It provides a sticky (nonzero-discarded) output. It is instantiated twice, once for the accumulator and once for the input operand.

## Test plan
- Single beat: dp=100, scale=10, last=1 → next cycle `o_valid`=1, `o_dp`=100, `o_scale`=10, `o_beats`=1.
- Equal scales: 5, −3, 7 at scale 4, last on third → `o_dp`=9, `o_scale`=4, `o_beats`=3.
- Alignment: 65 at scale 2, then 8 at scale 5 with last → acc 65>>3=8, `o_dp`=16, `o_scale`=5; `o_inexact`=1 when `DOT_ACC_STICKY_EN` is defined.
- Overflow with `acc_width`=18: 131071 + 131071 at scale 0 → `o_dp`=131071, `o_scale`=1. Repeat at scale 255 → clamp to 131071, `o_overflow`=1.
- Backpressure: hold `i_ready`=0 for 5 cycles with result pending and `i_valid`=1 → `o_ready`=0, outputs stable, no beat accepted. Release → result taken, `o_ready`=1 the next cycle.
- Reset: drop `i_rst_n` after 2 of 4 beats → all outputs at reset values immediately. A new single beat 3 at scale 0 then gives `o_dp`=3, `o_beats`=1.
